mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised, iterative multiply/divide unit that replaces the fixed-delay behavioural HI/LO unit in the execute stage.
- Implements a shift-add multiplier and a restoring divider, producing one result bit per cycle.
- Adds multiply-accumulate and multiply-subtract (MADD/MADDU/MSUB/MSUBU) into HI/LO.
- Adds a cancel input, so an exception flush aborts an in-flight operation without corrupting HI/LO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  operation request, sampled only when busy=0
- op  in  4  operation code (encodings in mdu_pkg)
- src_a  in  WIDTH  rs operand
- src_b  in  WIDTH  rt operand
- cancel  in  1  abort the in-flight operation (pipeline flush)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: HI/LO were updated by an iterative op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE. Reset mid-operation aborts with no done pulse. Reset has priority over all other inputs.
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, NOP. Undefined codes behave as NOP.
- MTHI/MTLO are accepted only in IDLE:
  - hi (or lo) <= src_a; the new value is visible the next cycle.
  - busy and done stay 0.
- Iterative op accepted in cycle T (start=1, busy=0, cancel=0):
  - busy=1 for exactly WIDTH+2 cycles (T+1 .. T+WIDTH+2).
  - In cycle T+WIDTH+3: new hi/lo visible, done=1, busy=0, and a new start may be accepted.
- FSM states: IDLE -> PREP (1 cycle) -> RUN (WIDTH cycles, counter WIDTH-1 down to 0) -> FIX (1 cycle, writes HI/LO) -> IDLE.
  - PREP: capture operand magnitudes and the result sign(s) for signed ops; the magnitude of -2^(WIDTH-1) fits unsigned in WIDTH bits.
  - RUN, multiply: shift-add, 2*WIDTH-bit partial product.
  - RUN, divide: restoring step, remainder WIDTH+1 bits.
  - FIX: apply signs, then write HI/LO.
- Multiply: {hi,lo} <= full 2*WIDTH-bit product (signed or unsigned).
- MADD(U)/MSUB(U): {hi,lo} <= {hi,lo} +/- product, modulo 2^(2*WIDTH). HI/LO as held at FIX are used; they cannot change while busy.
- DIV/DIVU:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - src_b=0: hi=0, lo=0, normal latency, done still pulses.
  - DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1), hi=0 (wraps, no trap).
- start while busy=1 is ignored; the upstream stage must stall on busy. The bench asserts this never happens.
- cancel while busy:
  - Next cycle: busy=0, state IDLE, no done.
  - hi/lo keep their pre-operation values.
  - cancel in the FIX cycle also suppresses the write.
- cancel in the same cycle as start: start is dropped (cancel wins). cancel in IDLE has no effect.
- Operands are latched in PREP; src_a/src_b/op may change freely while busy.

Decomposition:
- mdu_pkg holds:
  - op encoding constants (MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_MTHI, MDU_MTLO);
  - FSM state constants (ST_IDLE, ST_PREP, ST_RUN, ST_FIX).
- One sub-module, mdu_iter_core:
  - datapath for one iteration per cycle: shift-add multiply / restoring divide on magnitudes, with the counter.
  - The top level keeps the FSM, sign handling, accumulate, cancel and the HI/LO registers.

Test Plan:
- WIDTH=32, MULT src_a=0xFFFFFFFD (-3), src_b=5, start at T -> busy=1 for cycles T+1..T+34; at T+35 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 -> lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide boundaries:
  - DIV x/0 -> hi=0, lo=0, done at T+35.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0, MTLO 10, then MADD 3*4 -> hi=0, lo=22.
- MSUBU 0xFFFFFFFF*2 from {0,0} -> {hi,lo}=0xFFFFFFFE_00000002.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Start MULT with hi=0x11, lo=0x22 and assert cancel at T+10 -> busy=0 at T+11, no done, hi=0x11, lo=0x22; a new start at T+11 is accepted.
- Reset at T+20 of a DIV -> hi=lo=0, busy=0, no done.
- start in the same cycle as cancel -> no busy.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and op decode helpers for the iterative MDU
package mdu_pkg;
  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MADD  = 4'd5;
  localparam logic [3:0] MDU_MADDU = 4'd6;
  localparam logic [3:0] MDU_MSUB  = 4'd7;
  localparam logic [3:0] MDU_MSUBU = 4'd8;
  localparam logic [3:0] MDU_MTHI  = 4'd9;
  localparam logic [3:0] MDU_MTLO  = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_RUN, ST_FIX} state_t;

  function automatic logic is_iter(input logic [3:0] o);
    return o >= MDU_MULT && o <= MDU_MSUBU;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    return o == MDU_MULT || o == MDU_DIV || o == MDU_MADD || o == MDU_MSUB;
  endfunction

  function automatic logic is_div(input logic [3:0] o);
    return o == MDU_DIV || o == MDU_DIVU;
  endfunction
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one-bit-per-cycle shift-add multiply / restoring divide on magnitudes
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);
  localparam int CW = $clog2(WIDTH);
  // multiply: p = {partial sum, multiplier}; divide: p = {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   b;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     t;
  logic               ge;
  logic [WIDTH-1:0]   d;
  logic [2*WIDTH-1:0] nxt;
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
    t   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge  = t >= {1'b0, b};
    d   = t[WIDTH-1:0] - b;
    nxt = div ? {ge ? d : t[WIDTH-1:0], p[WIDTH-2:0], ge} : {sum, p[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      p   <= '0;
      b   <= '0;
      cnt <= '0;
    end else if (load) begin
      p   <= {{WIDTH{1'b0}}, mag_a};
      b   <= mag_b;
      cnt <= CW'(WIDTH - 1);
    end else if (step) begin
      p   <= nxt;
      cnt <= cnt - 1'b1;
    end
  end
  assign last = cnt == '0;
  assign prod = p;
  assign quot = p[WIDTH-1:0];
  assign rem  = p[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide/accumulate unit with HI/LO and flush cancel
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_q, neg_r, b_zero;
  logic               sgn, last;
  logic [WIDTH-1:0]   mag_a, mag_b, quot, rem;
  logic [2*WIDTH-1:0] prod, prod_s, res;
  always_comb begin
    sgn    = is_signed_op(op_q);
    mag_a  = sgn && a_q[WIDTH-1] ? -a_q : a_q;
    mag_b  = sgn && b_q[WIDTH-1] ? -b_q : b_q;
    prod_s = neg_q ? -prod : prod;
    res    = is_div(op_q) ? (b_zero ? '0 : {neg_r ? -rem : rem, neg_q ? -quot : quot})
           : (op_q == MDU_MADD || op_q == MDU_MADDU) ? {hi, lo} + prod_s
           : (op_q == MDU_MSUB || op_q == MDU_MSUBU) ? {hi, lo} - prod_s
           : prod_s;
  end
  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_PREP),
    .step  (state == ST_RUN),
    .div   (is_div(op_q)),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .last  (last),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start && !cancel) begin
          if (is_iter(op)) begin
            state <= ST_PREP;
            busy  <= 1'b1;
            op_q  <= op;
            a_q   <= src_a;
            b_q   <= src_b;
          end
          hi <= op == MDU_MTHI ? src_a : hi;
          lo <= op == MDU_MTLO ? src_a : lo;
        end
        ST_PREP: begin
          neg_q  <= sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r  <= sgn && a_q[WIDTH-1];
          b_zero <= b_q == '0;
          state  <= cancel ? ST_IDLE : ST_RUN;
          busy   <= !cancel;
        end
        ST_RUN: if (cancel) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else if (last) begin
          state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= !cancel;
          if (!cancel) {hi, lo} <= res;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter with directed vectors
module tb_mdu_iter;
  import mdu_pkg::*;
  logic        clk = 0, reset = 1, start = 0, cancel = 0;
  logic [3:0]  op = MDU_NOP;
  logic [31:0] src_a = 0, src_b = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // monitor: every done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  always @(posedge clk) if (!reset) assert (!(start && busy)) else $error("start while busy");

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] want);
    exp_q.push_back(want);
    start = 1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 0; op = MDU_NOP; src_a = $urandom; src_b = $urandom;
    cyc = 0;
    while (busy && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cyc), 64'd34);
    check({name, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] a);
    start = 1; op = o; src_a = a;
    @(negedge clk);
    start = 0; op = MDU_NOP;
    check("mt_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);

    do_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    do_op("divu", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    do_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    do_op("div_zero", MDU_DIV, 32'd123, 32'd0, 64'd0);
    do_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    mt(MDU_MTHI, 32'd0);
    mt(MDU_MTLO, 32'd10);
    check("mthi_mtlo", {hi, lo}, 64'd10);
    do_op("madd", MDU_MADD, 32'd3, 32'd4, 64'd22);
    mt(MDU_MTLO, 32'd0);
    do_op("msubu", MDU_MSUBU, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFE_00000002);
    do_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    mt(MDU_MTHI, 32'd0);
    mt(MDU_MTLO, 32'd0);
    do_op("msub_neg", MDU_MSUB, 32'hFFFFFFFE, 32'd3, 64'd6);
    do_op("madd_neg", MDU_MADD, 32'hFFFFFFFE, 32'd3, 64'd0);

    // cancel at T+10, new start accepted at T+11
    mt(MDU_MTHI, 32'h11);
    mt(MDU_MTLO, 32'h22);
    start = 1; op = MDU_MULT; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel_busy_done", {62'd0, busy, done}, 64'd0);
    check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
    do_op("after_cancel", MDU_MULT, 32'd3, 32'd5, 64'd15);

    // reset at T+20 of a divide
    mt(MDU_MTHI, 32'h55);
    start = 1; op = MDU_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_mid_later", {62'd0, busy, done}, 64'd0);

    // start with cancel is dropped
    start = 1; cancel = 1; op = MDU_MULT; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 0; cancel = 0;
    check("start_cancel_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("start_cancel_hilo", {hi, lo}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
